// File: rtl/riscv_formal_emit_pkg.sv
// riscv_formal_emit_pkg: shared RVFI field widths and the packed layout of an entry's fixed-width fields
package riscv_formal_emit_pkg;
  localparam int REG_W    = 5;
  localparam int INSN_W   = 32;
  localparam int ORDER_W  = 64;
  localparam int RD_LSB   = 0;
  localparam int RS2_LSB  = REG_W;
  localparam int RS1_LSB  = 2 * REG_W;
  localparam int INSN_LSB = 3 * REG_W;
  localparam int FIX_W    = INSN_W + 3 * REG_W;
  typedef logic [FIX_W-1:0] fix_t;
  function automatic fix_t pack_fix(input logic [INSN_W-1:0] insn, input logic [REG_W-1:0] rs1,
                                    input logic [REG_W-1:0] rs2, input logic [REG_W-1:0] rd);
    return {insn, rs1, rs2, rd};
  endfunction
endpackage

// File: rtl/riscv_formal_emit_buf.sv
// riscv_formal_emit_buf: in-flight entry ring with head/complete/tail pointers; trap flush under RISCV_FORMAL_TRAP_FLUSH_EN
module riscv_formal_emit_buf
  import riscv_formal_emit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [XLEN-1:0]   issue_pc,
  input  logic [INSN_W-1:0] issue_insn,
  input  logic [REG_W-1:0]  issue_rs1,
  input  logic [REG_W-1:0]  issue_rs2,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [XLEN-1:0]   issue_pre_rs1,
  input  logic [XLEN-1:0]   issue_pre_rs2,
  input  logic              cmpl_valid,
  input  logic [XLEN-1:0]   cmpl_post_rd,
  input  logic [XLEN-1:0]   cmpl_post_pc,
  input  logic              cmpl_trap,
  output logic              cmpl_err,
  output logic              pop,
  output logic [XLEN-1:0]   head_pc,
  output logic [INSN_W-1:0] head_insn,
  output logic [REG_W-1:0]  head_rs1,
  output logic [REG_W-1:0]  head_rs2,
  output logic [REG_W-1:0]  head_rd,
  output logic [XLEN-1:0]   head_pre_rs1,
  output logic [XLEN-1:0]   head_pre_rs2,
  output logic [XLEN-1:0]   head_post_rd,
  output logic [XLEN-1:0]   head_post_pc,
  output logic              head_trap
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  logic [AW-1:0] head, cptr, tail;
  logic [CW-1:0] count, pend;
  logic [DEPTH-1:0] done;
  logic [XLEN-1:0] pc_mem [DEPTH];
  fix_t fix_mem [DEPTH];
  logic [XLEN-1:0] pre1_mem [DEPTH];
  logic [XLEN-1:0] pre2_mem [DEPTH];
  logic [XLEN-1:0] prd_mem [DEPTH];
  logic [XLEN-1:0] ppc_mem [DEPTH];
  logic [DEPTH-1:0] trap_mem;
  logic push, cmpl, flush;
  // pend counts issued-but-uncompleted entries, so a completion needs an entry pushed on an earlier edge
  assign issue_ready = count < CAP;
  assign cmpl = cmpl_valid && pend != '0;
  assign pop = count != '0 && done[head];
`ifdef RISCV_FORMAL_TRAP_FLUSH_EN
  assign flush = cmpl && cmpl_trap;
`else
  assign flush = 1'b0;
`endif
  assign push = issue_valid && issue_ready && !flush;
  assign head_pc      = pc_mem[head];
  assign head_insn    = fix_mem[head][INSN_LSB +: INSN_W];
  assign head_rs1     = fix_mem[head][RS1_LSB +: REG_W];
  assign head_rs2     = fix_mem[head][RS2_LSB +: REG_W];
  assign head_rd      = fix_mem[head][RD_LSB +: REG_W];
  assign head_pre_rs1 = pre1_mem[head];
  assign head_pre_rs2 = pre2_mem[head];
  assign head_post_rd = prd_mem[head];
  assign head_post_pc = ppc_mem[head];
  assign head_trap    = trap_mem[head];
  // entry payload storage: issue fields at tail, completion fields at the complete pointer
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= issue_pc;
      fix_mem[tail]  <= pack_fix(issue_insn, issue_rs1, issue_rs2, issue_rd);
      pre1_mem[tail] <= issue_pre_rs1;
      pre2_mem[tail] <= issue_pre_rs2;
    end
    if (cmpl) begin
      prd_mem[cptr]  <= cmpl_post_rd;
      ppc_mem[cptr]  <= cmpl_post_pc;
      trap_mem[cptr] <= cmpl_trap;
    end
  end
  // pointers, occupancy, done flags and the sticky error; a flush keeps only the completed prefix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      cptr     <= '0;
      tail     <= '0;
      count    <= '0;
      pend     <= '0;
      done     <= '0;
      cmpl_err <= 1'b0;
    end else begin
      head     <= pop ? head + AW'(1) : head;
      cptr     <= cmpl ? cptr + AW'(1) : cptr;
      tail     <= flush ? cptr + AW'(1) : push ? tail + AW'(1) : tail;
      count    <= flush ? count - pend + CW'(1) - CW'(pop) : count + CW'(push) - CW'(pop);
      pend     <= flush ? '0 : pend + CW'(push) - CW'(cmpl);
      cmpl_err <= cmpl_err | (cmpl_valid && pend == '0);
      if (push) done[tail] <= 1'b0;
      if (pop) done[head] <= 1'b0;
      if (cmpl) done[cptr] <= 1'b1;
    end
  end
endmodule

// File: rtl/riscv_formal_rvfi_emitter.sv
// riscv_formal_rvfi_emitter: in-order RVFI retirement packet emitter; RISCV_FORMAL_TRAP_FLUSH_EN enables trap flush
module riscv_formal_rvfi_emitter
  import riscv_formal_emit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [XLEN-1:0]    issue_pc,
  input  logic [INSN_W-1:0]  issue_insn,
  input  logic [REG_W-1:0]   issue_rs1,
  input  logic [REG_W-1:0]   issue_rs2,
  input  logic [REG_W-1:0]   issue_rd,
  input  logic [XLEN-1:0]    issue_pre_rs1,
  input  logic [XLEN-1:0]    issue_pre_rs2,
  input  logic               cmpl_valid,
  input  logic [XLEN-1:0]    cmpl_post_rd,
  input  logic [XLEN-1:0]    cmpl_post_pc,
  input  logic               cmpl_trap,
  output logic               cmpl_err,
  output logic               rvfi_valid,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic [INSN_W-1:0]  rvfi_insn,
  output logic [REG_W-1:0]   rvfi_rs1,
  output logic [REG_W-1:0]   rvfi_rs2,
  output logic [REG_W-1:0]   rvfi_rd,
  output logic [XLEN-1:0]    rvfi_pre_pc,
  output logic [XLEN-1:0]    rvfi_pre_rs1,
  output logic [XLEN-1:0]    rvfi_pre_rs2,
  output logic [XLEN-1:0]    rvfi_post_pc,
  output logic [XLEN-1:0]    rvfi_post_rd,
  output logic               rvfi_post_trap
);
  logic pop, h_trap, s_valid, s_trap;
  logic [XLEN-1:0] h_pc, h_pre1, h_pre2, h_prd, h_ppc, s_pc, s_pre1, s_pre2, s_prd, s_ppc;
  logic [INSN_W-1:0] h_insn, s_insn;
  logic [REG_W-1:0] h_rs1, h_rs2, h_rd, s_rs1, s_rs2, s_rd;
  logic [ORDER_W-1:0] order_cnt;
  riscv_formal_emit_buf #(.XLEN(XLEN), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_insn(issue_insn),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_pre_rs1(issue_pre_rs1), .issue_pre_rs2(issue_pre_rs2),
    .cmpl_valid(cmpl_valid), .cmpl_post_rd(cmpl_post_rd), .cmpl_post_pc(cmpl_post_pc),
    .cmpl_trap(cmpl_trap), .cmpl_err(cmpl_err),
    .pop(pop), .head_pc(h_pc), .head_insn(h_insn),
    .head_rs1(h_rs1), .head_rs2(h_rs2), .head_rd(h_rd),
    .head_pre_rs1(h_pre1), .head_pre_rs2(h_pre2),
    .head_post_rd(h_prd), .head_post_pc(h_ppc), .head_trap(h_trap)
  );
  // retire stage: capture the head entry on the edge it leaves the ring
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_pc    <= '0;
      s_insn  <= '0;
      s_rs1   <= '0;
      s_rs2   <= '0;
      s_rd    <= '0;
      s_pre1  <= '0;
      s_pre2  <= '0;
      s_prd   <= '0;
      s_ppc   <= '0;
      s_trap  <= 1'b0;
    end else begin
      s_valid <= pop;
      if (pop) begin
        s_pc   <= h_pc;
        s_insn <= h_insn;
        s_rs1  <= h_rs1;
        s_rs2  <= h_rs2;
        s_rd   <= h_rd;
        s_pre1 <= h_pre1;
        s_pre2 <= h_pre2;
        s_prd  <= h_prd;
        s_ppc  <= h_ppc;
        s_trap <= h_trap;
      end
    end
  end
  // RVFI packet registers and order counter; payload only changes on a retirement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      order_cnt      <= '0;
      rvfi_insn      <= '0;
      rvfi_rs1       <= '0;
      rvfi_rs2       <= '0;
      rvfi_rd        <= '0;
      rvfi_pre_pc    <= '0;
      rvfi_pre_rs1   <= '0;
      rvfi_pre_rs2   <= '0;
      rvfi_post_pc   <= '0;
      rvfi_post_rd   <= '0;
      rvfi_post_trap <= 1'b0;
    end else begin
      rvfi_valid <= s_valid;
      if (s_valid) begin
        rvfi_order     <= order_cnt;
        order_cnt      <= order_cnt + ORDER_W'(1);
        rvfi_insn      <= s_insn;
        rvfi_rs1       <= s_rs1;
        rvfi_rs2       <= s_rs2;
        rvfi_rd        <= s_rd;
        rvfi_pre_pc    <= s_pc;
        rvfi_pre_rs1   <= s_pre1;
        rvfi_pre_rs2   <= s_pre2;
        rvfi_post_pc   <= s_ppc;
        rvfi_post_rd   <= s_rd == '0 ? '0 : s_prd;
        rvfi_post_trap <= s_trap;
      end
    end
  end
endmodule

// File: tb/tb_riscv_formal_rvfi_emitter.sv
// tb_riscv_formal_rvfi_emitter: directed table plus corner-case sequences for the RVFI emitter
module tb_riscv_formal_rvfi_emitter;
  logic clk = 1'b0, reset = 1'b1;
  logic issue_valid, issue_ready, cmpl_valid, cmpl_trap, cmpl_err;
  logic [31:0] issue_pc, issue_insn, issue_pre_rs1, issue_pre_rs2, cmpl_post_rd, cmpl_post_pc;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic rvfi_valid, rvfi_post_trap;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn, rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd;
  logic [4:0] rvfi_rs1, rvfi_rs2, rvfi_rd;
  int checks = 0, failures = 0;
  logic rdy_seen, all_rdy, found;

  riscv_formal_rvfi_emitter #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pc(issue_pc), .issue_insn(issue_insn),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_pre_rs1(issue_pre_rs1), .issue_pre_rs2(issue_pre_rs2),
    .cmpl_valid(cmpl_valid), .cmpl_post_rd(cmpl_post_rd), .cmpl_post_pc(cmpl_post_pc),
    .cmpl_trap(cmpl_trap), .cmpl_err(cmpl_err),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_rs1(rvfi_rs1), .rvfi_rs2(rvfi_rs2), .rvfi_rd(rvfi_rd),
    .rvfi_pre_pc(rvfi_pre_pc), .rvfi_pre_rs1(rvfi_pre_rs1), .rvfi_pre_rs2(rvfi_pre_rs2),
    .rvfi_post_pc(rvfi_post_pc), .rvfi_post_rd(rvfi_post_rd), .rvfi_post_trap(rvfi_post_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] order;
    logic [31:0] pc, post_rd, post_pc;
    logic trap;
  } rec_t;
  rec_t q[$];

  // retirement log, sampled mid-cycle
  always @(negedge clk)
    if (!reset && rvfi_valid) q.push_back('{rvfi_order, rvfi_pre_pc, rvfi_post_rd, rvfi_post_pc, rvfi_post_trap});

  typedef struct {
    logic iv;
    logic [31:0] pc, insn;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] p1, p2;
    logic cv;
    logic [31:0] prd, ppc;
    logic e_valid, pay;
    logic [63:0] e_order;
    logic [31:0] e_pc, e_insn;
    logic [4:0] e_rd;
    logic [31:0] e_p1, e_prd, e_ppc;
  } vec_t;
  vec_t tv[11];

  function automatic vec_t vn();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t vi(input logic [31:0] pc, insn, input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] p1, p2);
    vec_t v;
    v = vn();
    v.iv = 1'b1; v.pc = pc; v.insn = insn; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.p1 = p1; v.p2 = p2;
    return v;
  endfunction

  function automatic vec_t vc(input logic [31:0] prd, ppc);
    vec_t v;
    v = vn();
    v.cv = 1'b1; v.prd = prd; v.ppc = ppc;
    return v;
  endfunction

  function automatic vec_t wp(input vec_t b, input logic val, input logic [63:0] order,
                              input logic [31:0] pc, insn, input logic [4:0] rd,
                              input logic [31:0] p1, prd, ppc);
    vec_t v;
    v = b;
    v.pay = 1'b1; v.e_valid = val; v.e_order = order; v.e_pc = pc; v.e_insn = insn;
    v.e_rd = rd; v.e_p1 = p1; v.e_prd = prd; v.e_ppc = ppc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic [4:0] rd,
                       input logic cv, input logic [31:0] prd, input logic [31:0] ppc, input logic tr);
    issue_valid = iv; issue_pc = pc; issue_insn = pc ^ 32'h13;
    issue_rs1 = rd + 5'd1; issue_rs2 = rd + 5'd2; issue_rd = rd;
    issue_pre_rs1 = pc ^ 32'h55; issue_pre_rs2 = pc ^ 32'haa;
    cmpl_valid = cv; cmpl_post_rd = prd; cmpl_post_pc = ppc; cmpl_trap = tr;
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic [4:0] rd,
                      input logic cv, input logic [31:0] prd, input logic [31:0] ppc, input logic tr);
    drive(iv, pc, rd, cv, prd, ppc, tr);
    @(negedge clk);
    rdy_seen = issue_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", rvfi_valid, 0);
    chk("rst_order", rvfi_order, 0);
    chk("rst_pre_pc", rvfi_pre_pc, 0);
    chk("rst_post_rd", rvfi_post_rd, 0);
    chk("rst_err", cmpl_err, 0);
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = vi(32'h100, 32'h00500093, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0);
    tv[1]  = vc(32'd5, 32'h104);
    tv[2]  = vn();
    tv[3]  = vn();
    tv[4]  = wp(vn(), 1, 0, 32'h100, 32'h00500093, 5'd1, 32'h0, 32'd5, 32'h104);
    tv[5]  = wp(vi(32'h104, 32'h13, 5'd2, 5'd3, 5'd0, 32'haa, 32'hbb), 0, 0, 32'h100, 32'h00500093, 5'd1, 32'h0, 32'd5, 32'h104);
    tv[6]  = vc(32'd7, 32'h108);
    tv[7]  = vn();
    tv[8]  = vn();
    tv[9]  = wp(vn(), 1, 1, 32'h104, 32'h13, 5'd0, 32'haa, 32'd0, 32'h108);
    tv[10] = wp(vn(), 0, 1, 32'h104, 32'h13, 5'd0, 32'haa, 32'd0, 32'h108);

    do_reset();
    // table: single instruction, then an rd=0 instruction whose post_rd must read as 0
    for (int i = 0; i < 11; i++) begin
      issue_valid = tv[i].iv; issue_pc = tv[i].pc; issue_insn = tv[i].insn;
      issue_rs1 = tv[i].rs1; issue_rs2 = tv[i].rs2; issue_rd = tv[i].rd;
      issue_pre_rs1 = tv[i].p1; issue_pre_rs2 = tv[i].p2;
      cmpl_valid = tv[i].cv; cmpl_post_rd = tv[i].prd; cmpl_post_pc = tv[i].ppc; cmpl_trap = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), issue_ready, 1);
      chk($sformatf("v%0d_valid", i), rvfi_valid, tv[i].e_valid);
      chk($sformatf("v%0d_err", i), cmpl_err, 0);
      if (tv[i].pay) begin
        chk($sformatf("v%0d_order", i), rvfi_order, tv[i].e_order);
        chk($sformatf("v%0d_pc", i), rvfi_pre_pc, tv[i].e_pc);
        chk($sformatf("v%0d_insn", i), rvfi_insn, tv[i].e_insn);
        chk($sformatf("v%0d_rd", i), rvfi_rd, tv[i].e_rd);
        chk($sformatf("v%0d_pre_rs1", i), rvfi_pre_rs1, tv[i].e_p1);
        chk($sformatf("v%0d_post_rd", i), rvfi_post_rd, tv[i].e_prd);
        chk($sformatf("v%0d_post_pc", i), rvfi_post_pc, tv[i].e_ppc);
        chk($sformatf("v%0d_trap", i), rvfi_post_trap, 0);
      end
      @(posedge clk);
      #1;
    end

    // back-pressure: fill, refused issue while full, accepted after one retire
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h200 + 32'(4 * k), 5'(k + 1), 0, 0, 0, 0);
      chk($sformatf("bp_ready%0d", k), rdy_seen, 1);
    end
    step(1, 32'h300, 5'd9, 1, 32'h11, 32'h204, 0);
    chk("bp_full", rdy_seen, 0);
    step(1, 32'h300, 5'd9, 0, 0, 0, 0);
    chk("bp_full_pop", rdy_seen, 0);
    step(1, 32'h300, 5'd9, 0, 0, 0, 0);
    chk("bp_ready_again", rdy_seen, 1);
    idle(3);
    chk("bp_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("bp_order", q[0].order, 0);
      chk("bp_pc", q[0].pc, 32'h200);
      chk("bp_post_pc", q[0].post_pc, 32'h204);
    end

    // streaming: issue, complete and retire every cycle across two pointer wraps
    do_reset();
    all_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(k < 8, 32'h400 + 32'(4 * k), 5'(k + 1), k > 0, 32'h1000 + 32'(k - 1), 32'h400 + 32'(4 * k), 0);
      all_rdy = all_rdy & rdy_seen;
    end
    idle(4);
    chk("st_ready", all_rdy, 1);
    chk("st_count", q.size(), 8);
    for (int j = 0; j < 8 && j < q.size(); j++) begin
      chk($sformatf("st_order%0d", j), q[j].order, 64'(j));
      chk($sformatf("st_pc%0d", j), q[j].pc, 32'h400 + 32'(4 * j));
      chk($sformatf("st_post_rd%0d", j), q[j].post_rd, 32'h1000 + 32'(j));
    end

    // completion in the same cycle as the first issue is dropped and flagged
    do_reset();
    step(1, 32'h500, 5'd3, 1, 32'hdead, 32'h0, 0);
    chk("sp_same_err", cmpl_err, 1);
    step(0, 0, 0, 1, 32'h77, 32'h504, 0);
    idle(4);
    chk("sp_same_err_sticky", cmpl_err, 1);
    chk("sp_same_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("sp_same_order", q[0].order, 0);
      chk("sp_same_post_rd", q[0].post_rd, 32'h77);
    end

    // completion on an empty buffer
    do_reset();
    step(0, 0, 0, 1, 32'h1, 32'h2, 0);
    idle(4);
    chk("sp_err", cmpl_err, 1);
    chk("sp_no_retire", q.size(), 0);

`ifdef RISCV_FORMAL_TRAP_FLUSH_EN
    // trap flush: younger entries and the same-cycle issue vanish
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 32'h600 + 32'(4 * k), 5'(k + 1), 0, 0, 0, 0);
    step(1, 32'h700, 5'd5, 1, 32'h1, 32'h604, 1);
    idle(4);
    chk("tf_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("tf_trap", q[0].trap, 1);
      chk("tf_order", q[0].order, 0);
    end
    for (int k = 0; k < 4; k++) begin
      step(1, 32'h800 + 32'(4 * k), 5'(k + 1), 0, 0, 0, 0);
      chk($sformatf("tf_empty_ready%0d", k), rdy_seen, 1);
    end
    step(1, 32'h900, 5'd1, 1, 32'h2, 32'h804, 0);
    chk("tf_full", rdy_seen, 0);
    idle(4);
    chk("tf_count2", q.size(), 2);
    if (q.size() > 1) begin
      chk("tf_order2", q[1].order, 1);
      chk("tf_pc2", q[1].pc, 32'h800);
      chk("tf_trap2", q[1].trap, 0);
    end
`else
    // trap without flush: recorded on the packet, younger entry still retires
    do_reset();
    step(1, 32'h600, 5'd1, 0, 0, 0, 0);
    step(1, 32'h604, 5'd2, 1, 32'h1, 32'h10, 1);
    step(0, 0, 0, 1, 32'h2, 32'h608, 0);
    idle(4);
    chk("tr_count", q.size(), 2);
    if (q.size() > 1) begin
      chk("tr_trap0", q[0].trap, 1);
      chk("tr_post_pc0", q[0].post_pc, 32'h10);
      chk("tr_trap1", q[1].trap, 0);
      chk("tr_order1", q[1].order, 1);
      chk("tr_pc1", q[1].pc, 32'h604);
    end
`endif

    // reset while a packet is being presented and another entry is outstanding
    do_reset();
    step(1, 32'ha00, 5'd1, 0, 0, 0, 0);
    step(1, 32'ha04, 5'd2, 1, 32'h3, 32'ha04, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #2;
      found = rvfi_valid;
    end
    chk("mr_found", found, 1);
    reset = 1'b1;
    #1;
    chk("mr_valid", rvfi_valid, 0);
    chk("mr_pre_pc", rvfi_pre_pc, 0);
    chk("mr_post_rd", rvfi_post_rd, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    chk("mr_ready", issue_ready, 1);
    step(1, 32'hb00, 5'd4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h9, 32'hb04, 0);
    idle(4);
    chk("mr_err", cmpl_err, 0);
    chk("mr_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("mr_order", q[0].order, 0);
      chk("mr_pc", q[0].pc, 32'hb00);
      chk("mr_post_rd", q[0].post_rd, 32'h9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_formal_rvfi_emitter.md
RISCV_FORMAL_RVFI_EMITTER -- requirements
Module: riscv_formal_rvfi_emitter

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and PC width.
REQ-002 SHALL have parameter DEPTH, default 4 (power of two, at least 2): in-flight entry count.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have issue_valid/issue_ready, input/output, 1 each: issue handshake; transfer occurs when both are high at an edge.
REQ-006 SHALL have issue_pc (XLEN), issue_insn (32), issue_rs1/issue_rs2/issue_rd (5 each), issue_pre_rs1/issue_pre_rs2 (XLEN), all inputs: issue payload.
REQ-007 SHALL have cmpl_valid (1), cmpl_post_rd (XLEN), cmpl_post_pc (XLEN), cmpl_trap (1), all inputs: completion of the oldest uncompleted entry.
REQ-008 SHALL have cmpl_err, output, 1: sticky flag for a completion received with no uncompleted entry.
REQ-009 SHALL have outputs rvfi_valid (1), rvfi_order (64), rvfi_insn (32), rvfi_rs1/rvfi_rs2/rvfi_rd (5 each), rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd (XLEN each), and rvfi_post_trap (1): single-channel retirement packet.

Function
REQ-010 SHALL store issued entries in a circular buffer of DEPTH slots with head, complete and tail pointers, each log2(DEPTH) bits wide and wrapping modulo DEPTH.
REQ-011 SHALL drive issue_ready = (count < DEPTH), with no same-cycle pop bypass.
REQ-012 SHALL apply a completion to the slot at the complete pointer only if that slot was issued on an earlier edge; otherwise the completion is dropped and cmpl_err is set.
REQ-013 SHALL accept at most one issue, one completion and one retire per cycle, all three in the same cycle when legal.
REQ-014 SHALL retire the head entry once its done flag is set, with registered outputs: rvfi_valid is high for exactly one cycle, starting on the second rising edge after the edge that sampled cmpl_valid.
REQ-015 SHALL hold all rvfi_* payload outputs stable while rvfi_valid is low, and clear rvfi_post_rd to 0 when the retired rd is 0.
REQ-016 SHALL increment rvfi_order by 1 after each retirement; the first retirement carries order 0, and the counter wraps at 2^64.
REQ-017 SHALL, when an issue and a retire occur in the same cycle with the buffer full, refuse the issue that cycle and accept it on the next cycle.

Reset
REQ-018 SHALL, while reset is high, asynchronously clear all pointers, count, done flags, cmpl_err, rvfi_valid, rvfi_order and every rvfi_* payload output to 0.
REQ-019 SHALL, on reset asserted mid-operation, discard all in-flight entries without retiring them; issue_ready is 1 on the first cycle after reset deasserts.

Configuration
REQ-020 SHALL, with RISCV_FORMAL_TRAP_FLUSH_EN defined, on a completion with cmpl_trap=1 mark that entry done, discard all younger entries and any same-cycle issue, and set the tail to the complete pointer plus 1.
REQ-021 SHALL, without RISCV_FORMAL_TRAP_FLUSH_EN, record cmpl_trap into rvfi_post_trap only, with no flush.

Structure
REQ-022 SHALL place the RVFI field widths, the order width (64) and the entry field layout constants in shared package riscv_formal_emit_pkg.
REQ-023 SHALL implement entry storage and pointer arithmetic in one sub-module, riscv_formal_emit_buf; retire registers and the order counter stay in the top module.

Verification
REQ-024 SHALL cover single instruction: issue pc=0x100, insn=0x00500093, rd=1, then complete post_rd=5, post_pc=0x104 -> one rvfi_valid pulse with order=0, rd=1, post_rd=5, post_pc=0x104.
REQ-025 SHALL cover full/back-pressure: issue DEPTH=4 entries with no completion -> issue_ready=0; one complete plus retire -> issue_ready returns to 1 and rvfi_order of that retirement is 0.
REQ-026 SHALL cover simultaneous traffic: issue, complete and retire in the same cycle for 8 back-to-back instructions -> orders 0..7 in sequence, pointers wrap twice, no loss.
REQ-027 SHALL cover spurious completion: cmpl_valid with an empty buffer -> cmpl_err=1 and stays 1, no rvfi_valid.
REQ-028 SHALL cover trap flush (macro on): 3 entries issued, first completes with cmpl_trap=1 -> one retire with post_trap=1, count=0, next issue retires with order 1.
REQ-029 SHALL cover reset mid-stream: reset asserted with 2 entries outstanding -> rvfi_valid=0 at once, next retirement after reset carries order 0.
